// File: rtl/vsynth_voice_pkg.sv
// Shared definitions for the voice allocator: voice-state encodings,
// default geometry and a constant clog2 helper.
package vsynth_voice_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_NOTE_W     = 7;

  typedef enum logic [1:0] {
    VS_FREE = 2'd0,
    VS_HELD = 2'd1,
    VS_REL  = 2'd2
  } vstate_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Age permutation for the voice pool; age 0 is the most recently triggered
// voice. Also reports the oldest RELEASING and oldest HELD voice.
module voice_age_tracker
  import vsynth_voice_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int VID_W      = clog2(DEF_NUM_VOICES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             touch,
  input  logic [VID_W-1:0]                 touch_idx,
  input  logic [NUM_VOICES-1:0][1:0]       state,
  output logic [VID_W-1:0]                 old_rel_idx,
  output logic                             old_rel_vld,
  output logic [VID_W-1:0]                 old_held_idx,
  output logic                             old_held_vld
);

  logic [NUM_VOICES-1:0][VID_W-1:0] age;
  logic [VID_W-1:0]                 rel_age, held_age;

  // Touched voice becomes youngest; only voices younger than it shift up,
  // which keeps the ages a permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) age[i] <= VID_W'(i);
    end else if (touch) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (touch_idx == VID_W'(i))        age[i] <= '0;
        else if (age[i] < age[touch_idx])  age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    old_rel_vld  = 1'b0;
    old_rel_idx  = '0;
    rel_age      = '0;
    old_held_vld = 1'b0;
    old_held_idx = '0;
    held_age     = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (state[i] == VS_REL && (!old_rel_vld || age[i] > rel_age)) begin
        old_rel_vld = 1'b1;
        old_rel_idx = VID_W'(i);
        rel_age     = age[i];
      end
      if (state[i] == VS_HELD && (!old_held_vld || age[i] > held_age)) begin
        old_held_vld = 1'b1;
        old_held_idx = VID_W'(i);
        held_age     = age[i];
      end
    end
  end

endmodule

// File: rtl/adsr_voice_alloc.sv
// Polyphonic voice allocator: maps note events onto envelope voices, drives
// gate strobes, retriggers/steals voices and frees them on release complete.
module adsr_voice_alloc
  import vsynth_voice_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int VID_W      = clog2(NUM_VOICES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         note_on,
  input  logic                         note_off,
  input  logic [NOTE_W-1:0]            note_num,
  input  logic [NUM_VOICES-1:0]        voice_idle,
  output logic [NUM_VOICES-1:0]        gate_on,
  output logic [NUM_VOICES-1:0]        gate_off,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic                         steal
);

  logic [NUM_VOICES-1:0][1:0]        state;
  logic [NUM_VOICES-1:0][1:0]        st1;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes;

  logic             off_vld;
  logic [VID_W-1:0] off_idx;
  logic             hit_vld, free_vld;
  logic [VID_W-1:0] hit_idx, free_idx;
  logic             rel_vld, held_vld;
  logic [VID_W-1:0] rel_idx, held_idx;
  logic [VID_W-1:0] tgt;
  logic             tgt_steal;

  assign voice_note = notes;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) voice_busy[i] = (state[i] != VS_FREE);
  end

  // note_off resolves first; st1 is the state vector note_on selects against.
  always_comb begin
    off_vld = 1'b0;
    off_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (note_off && state[i] == VS_HELD && notes[i] == note_num) begin
        off_vld = 1'b1;
        off_idx = VID_W'(i);
      end
    end
    st1 = state;
    if (off_vld) st1[off_idx] = VS_REL;
  end

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .VID_W      (VID_W)
  ) u_age (
    .clk          (clk),
    .rst          (rst),
    .touch        (note_on),
    .touch_idx    (tgt),
    .state        (st1),
    .old_rel_idx  (rel_idx),
    .old_rel_vld  (rel_vld),
    .old_held_idx (held_idx),
    .old_held_vld (held_vld)
  );

  always_comb begin
    hit_vld  = 1'b0;
    hit_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (st1[i] != VS_FREE && notes[i] == note_num) begin
        hit_vld = 1'b1;
        hit_idx = VID_W'(i);
      end
      if (st1[i] == VS_FREE) begin
        free_vld = 1'b1;
        free_idx = VID_W'(i);
      end
    end
    tgt       = '0;
    tgt_steal = 1'b0;
    if (hit_vld) begin
      tgt = hit_idx;
    end else if (free_vld) begin
      tgt = free_idx;
    end else if (rel_vld) begin
      tgt       = rel_idx;
      tgt_steal = 1'b1;
    end else if (held_vld) begin
      tgt       = held_idx;
      tgt_steal = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= '0;
      notes    <= '0;
      gate_on  <= '0;
      gate_off <= '0;
      steal    <= 1'b0;
    end else begin
      steal <= note_on && tgt_steal;
      for (int i = 0; i < NUM_VOICES; i++) begin
        gate_on[i]  <= 1'b0;
        // A same-cycle note_on on the released voice is a retrigger: no gate_off.
        gate_off[i] <= off_vld && off_idx == VID_W'(i) &&
                       !(note_on && tgt == VID_W'(i));
        if (note_on && tgt == VID_W'(i)) begin
          state[i]   <= VS_HELD;
          notes[i]   <= note_num;
          gate_on[i] <= 1'b1;
        end else if (state[i] == VS_REL && voice_idle[i]) begin
          state[i] <= VS_FREE;
        end else begin
          state[i] <= st1[i];
        end
      end
    end
  end

endmodule

// File: doc/adsr_voice_alloc.md
Name: adsr_voice_alloc

Overview:
- Polyphonic voice allocator/scheduler that sits between the note-event decoder and NUM_VOICES envelope generator instances.
- Maps note-on/note-off events onto voices and drives each voice's single-cycle gate_on/gate_off strobes.
- Tracks per-voice state and age, and steals the oldest voice when none is free.
- Frees a voice only when its envelope reports release complete.

Parameters:
- NUM_VOICES, 4, number of envelope voices managed; power of two, 2..16.
- NOTE_W, 7, note-number width.
- VID_W, 2, voice index width; must equal clog2(NUM_VOICES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- note_on  in  1  single-cycle note-on event strobe.
- note_off  in  1  single-cycle note-off event strobe.
- note_num  in  NOTE_W  note for the event(s) in this cycle.
- voice_idle  in  NUM_VOICES  per voice: envelope finished release (output at 0, release phase done); level-sensitive.
- gate_on  out  NUM_VOICES  registered one-cycle strobe per voice; connects to the envelope gate_on.
- gate_off  out  NUM_VOICES  registered one-cycle strobe per voice; connects to the envelope gate_off.
- voice_note  out  NUM_VOICES*NOTE_W  note currently owned by each voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
- voice_busy  out  NUM_VOICES  voice is HELD or RELEASING.
- steal  out  1  one-cycle strobe: the last note_on stole a voice.

Behaviour:
- Reset values: all outputs 0; every voice FREE; voice i age = i.
- Per-voice state machine: FREE, HELD, RELEASING.
  - FREE -> HELD on allocation.
  - HELD -> RELEASING on a matching note_off.
  - RELEASING -> HELD on retrigger or steal.
  - RELEASING -> FREE when voice_idle[i]=1 and no event targets voice i this cycle.
  - HELD -> HELD on steal or retrigger.
- voice_idle is ignored for HELD and FREE voices.
- Events are accepted every cycle with no backpressure. Gate strobes, steal, voice_note and state updates appear at t+1 for an event at t.
- note_on target selection, first match wins:
  1. A HELD or RELEASING voice whose voice_note == note_num (retrigger; no steal).
  2. The lowest-index FREE voice.
  3. The oldest RELEASING voice (steal=1).
  4. The oldest HELD voice (steal=1).
- On note_on: target gets gate_on=1 and voice_note=note_num, and state becomes HELD.
- Ages:
  - Ages are a permutation of 0..NUM_VOICES-1; the largest age is the oldest voice.
  - On note_on, the target's age becomes 0. Every voice whose age is below the target's previous age increments by 1. Other ages are unchanged.
  - The permutation invariant must always hold.
- note_off:
  - Applies to the HELD voice with voice_note == note_num, lowest index if several match: gate_off=1, state becomes RELEASING.
  - No matching HELD voice: no effect and no strobe. This includes an already RELEASING voice.
  - Ages are not changed by note_off.
- Simultaneous note_on and note_off in one cycle: note_off is applied first, then note_on sees the updated state.
  - Same note: the voice is retriggered. Only gate_on pulses for it; gate_off is suppressed.
  - Different notes: both take effect. gate_off and gate_on may pulse on different voices in the same cycle.
- gate_on and gate_off are never both 1 for the same voice.
- Voice freeing on voice_idle takes effect one cycle after the sample. If a voice is freed and an event targets it in the same cycle, the event wins.
- Reset mid-operation: all state returns to reset values immediately. No gate_off is emitted; the envelopes are reset by the same rst.
- voice_note of a FREE voice keeps its last value. Only voice_busy marks validity.

Decomposition:
- Shared package/header vsynth_voice_pkg:
  - voice-state encodings (VS_FREE=2'd0, VS_HELD=2'd1, VS_REL=2'd2);
  - default NUM_VOICES and NOTE_W;
  - clog2 helper.
- Sub-module voice_age_tracker:
  - holds the age permutation;
  - inputs: touch strobe and touch index;
  - outputs: oldest-RELEASING index and oldest-HELD index, each with a valid flag, given the state vector.
- Target selection and the voice state machines stay in adsr_voice_alloc.

Test Plan:
- After reset, note_on with note 60 -> at t+1: gate_on=4'b0001, voice_note[0]=60, voice_busy=4'b0001, steal=0.
- note_on with notes 60, 62, 64, 65, 67 on consecutive cycles -> voices 0..3 allocated in order. Note 67 steals voice 0 (oldest HELD): gate_on[0]=1, steal=1, voice_note[0]=67.
- Hold 60 and 62, then note_off 60 -> gate_off[0]=1. Then note_on 64 with voices 2 and 3 FREE -> voice 2 is chosen, not the RELEASING voice 0.
- Voice 1 RELEASING; drive voice_idle[1]=1 -> voice_busy[1]=0 next cycle. Repeat with a same-cycle note_on retriggering voice 1's note -> voice stays HELD and gate_on[1]=1.
- Simultaneous note_off 60 and note_on 60 while voice 0 holds 60 -> gate_on[0]=1, gate_off[0]=0, state HELD. note_off for unheld note 70 -> no strobes.
- Assert rst while 3 voices are busy -> outputs 0 immediately and ages reset. Random event soak afterwards: the age permutation invariant always holds and gate_on & gate_off == 0 every cycle.
